// File: rtl/seg_scan_mux_pkg.sv
// Shared display constants for the multiplexed seven-segment scanner.
// Segment patterns are active-high and use the bit order {g,f,e,d,c,b,a}.
package seg_scan_mux_pkg;

  localparam int SEG_WIDTH = 7;

  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  typedef logic [SEG_WIDTH-1:0] seg_pattern_t;

  localparam seg_pattern_t HEX_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_pattern_t hex_to_seg(input logic [3:0] nibble);
    return HEX_PATTERNS[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_mux_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern decoder.
module seg_hex_decode
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0]   nibble,
  output seg_pattern_t pattern
);

  assign pattern = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with frame-synchronous display
// updates, guard blanking, per-digit masking and leading-zero suppression.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_BITS     = 12,
  parameter int GUARD_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick,
  output logic                    load_ack
);

  localparam logic             INV  = (ACTIVE_LOW != 0);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     presc;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic                    presc_max;
  logic                    boundary;

  assign presc_max = (presc == '1);
  assign boundary  = presc_max && (digit_idx == LAST);

  // Scan counters plus the pending/display double buffer; new data only
  // reaches the display at the frame boundary so a frame is never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      digit_idx  <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      presc      <= presc + 1'b1;
      frame_tick <= boundary;
      load_ack   <= 1'b0;
      if (presc_max) begin
        digit_idx <= (digit_idx == LAST) ? '0 : digit_idx + 1'b1;
      end
      if (boundary) begin
        if (load) begin
          disp_data <= data_in;
          disp_dp   <= dp_in;
          load_ack  <= 1'b1;
        end else if (pend_valid) begin
          disp_data <= pend_data;
          disp_dp   <= pend_dp;
          load_ack  <= 1'b1;
        end
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

  logic [3:0]            nibble;
  logic                  cur_dp;
  logic                  masked;
  logic                  nonzero_above;
  logic                  lz_dark;
  logic                  guard_dark;
  logic                  dark;
  logic [NUM_DIGITS-1:0] an_sel;
  seg_pattern_t          pattern;

  always_comb begin
    nibble        = 4'h0;
    cur_dp        = 1'b0;
    masked        = 1'b0;
    an_sel        = '0;
    nonzero_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        nibble    = disp_data[4*i +: 4];
        cur_dp    = disp_dp[i];
        masked    = blank_mask[i];
        an_sel[i] = 1'b1;
      end
      if ((i >= int'(digit_idx)) && (disp_data[4*i +: 4] != 4'h0)) begin
        nonzero_above = 1'b1;
      end
    end
    lz_dark    = lz_suppress && (digit_idx != '0) && !nonzero_above;
    guard_dark = (presc < DIV_BITS'(GUARD_CYCLES));
    dark       = guard_dark || masked || lz_dark;
  end

  seg_hex_decode u_decode (
    .nibble  (nibble),
    .pattern (pattern)
  );

  // Output register: drive levels are formed active-high, then flipped for
  // common-anode style hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {NUM_DIGITS{INV}};
      seg <= {7{INV}};
      dp  <= INV;
    end else begin
      an  <= (dark ? '0 : an_sel) ^ {NUM_DIGITS{INV}};
      seg <= (dark ? 7'h00 : pattern) ^ {7{INV}};
      dp  <= (dark ? 1'b0 : cur_dp) ^ INV;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized scoreboard bench for seg_scan_mux against a cycle-count based
// reference model of the scan, double buffer and blanking rules.
module tb_seg_scan_mux;

  localparam int ND    = 8;
  localparam int DB    = 4;
  localparam int GC    = 2;
  localparam int AL    = 1;
  localparam int DWELL = 1 << DB;

  localparam logic [6:0] HEX_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [31:0]   data_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] blank_mask = '0;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;
  logic [2:0]    digit_idx;
  logic          frame_tick;
  logic          load_ack;

  seg_scan_mux #(
    .NUM_DIGITS   (ND),
    .DIV_BITS     (DB),
    .GUARD_CYCLES (GC),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .digit_idx   (digit_idx),
    .frame_tick  (frame_tick),
    .load_ack    (load_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
    logic       ft;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   ack_seen     = 0;

  // Reference model state: time since reset, digits shown and queued data.
  int          tick = 0;
  logic [3:0]  disp_nib [ND];
  logic        disp_dpm [ND];
  logic [31:0] pend_data = '0;
  logic [7:0]  pend_dp = '0;
  logic        pend_valid = 1'b0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("an", 32'(an), 32'(e.an));
    checkValue("seg", 32'(seg), 32'(e.seg));
    checkValue("dp", 32'(dp), 32'(e.dp));
    checkValue("digit_idx", 32'(digit_idx), 32'(e.idx));
    checkValue("frame_tick", 32'(frame_tick), 32'(e.ft));
    checkValue("load_ack", 32'(load_ack), 32'(e.ack));
  endtask

  // Monitor: each falling edge shows the result of the preceding rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (load_ack === 1'b1) ack_seen++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic l, input logic [31:0] d,
                               input logic [7:0] dpv, input logic [7:0] m, input logic lz);
    exp_t e;
    int   p, dg;
    logic bnd, lead, dark;
    @(negedge clk);
    #1;
    rst = r; load = l; data_in = d; dp_in = dpv; blank_mask = m; lz_suppress = lz;
    e = '0;
    if (r) begin
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.idx = 3'd0;
      tick = 0; pend_valid = 1'b0; pend_data = '0; pend_dp = '0;
      for (int j = 0; j < ND; j++) begin
        disp_nib[j] = 4'h0;
        disp_dpm[j] = 1'b0;
      end
    end else begin
      p    = tick % DWELL;
      dg   = (tick / DWELL) % ND;
      bnd  = (p == DWELL - 1) && (dg == ND - 1);
      lead = lz && (dg != 0);
      for (int j = dg; j < ND; j++) if (disp_nib[j] != 4'h0) lead = 1'b0;
      dark  = (p < GC) || m[dg] || lead;
      e.an  = dark ? 8'hFF : ~(8'h01 << dg);
      e.seg = dark ? 7'h7F : ~HEX_LUT[disp_nib[dg]];
      e.dp  = dark ? 1'b1 : ~disp_dpm[dg];
      e.ft  = bnd;
      e.ack = bnd && (l || pend_valid);
      if (bnd) begin
        if (l || pend_valid) begin
          for (int j = 0; j < ND; j++) begin
            disp_nib[j] = l ? d[4*j +: 4] : pend_data[4*j +: 4];
            disp_dpm[j] = l ? dpv[j] : pend_dp[j];
          end
        end
        pend_valid = 1'b0;
      end else if (l) begin
        pend_data  = d;
        pend_dp    = dpv;
        pend_valid = 1'b1;
      end
      tick++;
      e.idx = 3'((tick / DWELL) % ND);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [7:0] m, input logic lz);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, $urandom, 8'($urandom), m, lz);
  endtask

  // Advance until the next applied cycle sits at prescaler tp of digit td.
  task automatic runUntil(input int tp, input int td, input logic [7:0] m, input logic lz);
    for (int k = 0; k < 4 * ND * DWELL; k++) begin
      if ((tick % DWELL == tp) && ((tick / DWELL) % ND == td)) return;
      applyStimulus(1'b0, 1'b0, $urandom, 8'($urandom), m, lz);
    end
    n_mismatched++;
    $display("[TB] FAIL runUntil timeout: got no match expected p=%0d d=%0d", tp, td);
  endtask

  initial begin
    int acks0;
    logic r, l, lz;
    logic [7:0] m;

    // Reset for two clocks, with load held high to exercise reset priority.
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 8'hFF, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 8'hFF, 8'h00, 1'b0);
    checkValue("reset_an", 32'(an), 32'hFF);
    checkValue("reset_seg", 32'(seg), 32'h7F);
    checkValue("reset_dp", 32'(dp), 32'h1);
    checkValue("reset_idx", 32'(digit_idx), 32'h0);
    checkValue("reset_ack", 32'(load_ack), 32'h0);

    // Mid-frame load only appears after the boundary.
    runUntil(7, 3, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 8'h00, 8'h00, 1'b0);
    idle(ND * DWELL, 8'h00, 1'b0);

    // Two loads in one frame: newest wins, one acknowledge.
    runUntil(3, 1, 8'h00, 1'b0);
    acks0 = ack_seen;
    applyStimulus(1'b0, 1'b1, 32'h11111111, 8'h00, 8'h00, 1'b0);
    runUntil(9, 4, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h22222222, 8'h00, 8'h00, 1'b0);
    runUntil(0, 3, 8'h00, 1'b0);
    checkValue("single_ack_count", 32'(ack_seen - acks0), 32'd1);

    // Load coincident with the boundary plus leading-zero suppression.
    runUntil(DWELL - 1, ND - 1, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h000000A0, 8'h00, 8'h00, 1'b1);
    idle(ND * DWELL + 4, 8'h00, 1'b1);

    // Digit 0 masked for a whole frame.
    idle(ND * DWELL, 8'h01, 1'b0);

    // Reset during digit 5 discards pending data.
    runUntil(2, 2, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h98765432, 8'hA5, 8'h00, 1'b0);
    runUntil(6, 5, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 8'h00, 1'b0);
    checkValue("rst_mid_idx", 32'(digit_idx), 32'h0);
    checkValue("rst_mid_an", 32'(an), 32'hFF);
    idle(2 * ND * DWELL, 8'h00, 1'b0);

    // Randomized traffic.
    m = 8'h00; lz = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) m = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 99) == 0) lz = ~lz;
      r = ($urandom_range(0, 999) == 0);
      l = ($urandom_range(0, 39) == 0);
      applyStimulus(r, l, $urandom >> $urandom_range(0, 31), 8'($urandom), m, lz);
    end

    idle(4, 8'h00, 1'b0);
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
